// File: rtl/frame_cfg_pkg.sv
// Shared definitions for the column configuration sequencer: FSM encoding, header layout, counter width.
// Header word: [31] marker, [23:16] column, [15:8] frame index, [7:0] row count.
package frame_cfg_pkg;

    localparam int CNT_W = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_SKIP   = 2'd2;
    localparam logic [1:0] ST_STROBE = 2'd3;

    localparam int HDR_MARK_BIT = 31;
    localparam int COL_MSB      = 23;
    localparam int COL_LSB      = 16;
    localparam int FRAME_MSB    = 15;
    localparam int FRAME_LSB    = 8;
    localparam int CNT_MSB      = 7;
    localparam int CNT_LSB      = 0;

    localparam logic HDR_MARKER = 1'b1;

    // Low 24 header bits, laid out to match the field positions above.
    typedef struct packed {
        logic [CNT_W-1:0] col;
        logic [CNT_W-1:0] frame;
        logic [CNT_W-1:0] n;
    } hdr_t;

endpackage

// File: rtl/frame_strobe_decode.sv
// Frame index to one-hot strobe decoder.
// Latency: combinational; the parent registers the result.
// Backpressure: none, pure function of its inputs.
module frame_strobe_decode #(
    parameter int MaxFramesPerCol = 20,
    parameter int IdxW            = 8
) (
    input  logic [IdxW-1:0]            frame_idx,
    input  logic                       en,
    output logic [MaxFramesPerCol-1:0] one_hot
);

    always_comb begin
        one_hot = '0;
        for (int i = 0; i < MaxFramesPerCol; i++) begin
            one_hot[i] = en && (frame_idx == IdxW'(i));
        end
    end

endmodule

// File: rtl/frame_strobe_sequencer.sv
// Loads row slices of one configuration frame from a word stream and pulses the frame's latch strobe.
// Latency: strobe visible one cycle after the last data word is accepted, held StrobeCycles cycles.
// Backpressure: cfg_ready low only while strobing; stalls on cfg_valid=0 extend LOAD/SKIP indefinitely.
module frame_strobe_sequencer
    import frame_cfg_pkg::*;
#(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int NumRows         = 16,
    parameter int ColIndex        = 0,
    parameter int StrobeCycles    = 2
) (
    input  logic                               UserCLK,
    input  logic                               resetn,
    input  logic                               cfg_valid,
    input  logic [FrameBitsPerRow-1:0]         cfg_data,
    output logic                               cfg_ready,
    output logic [FrameBitsPerRow*NumRows-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0]         FrameStrobe,
    output logic                               busy,
    output logic                               err
);

    localparam logic [CNT_W-1:0] MAX_FRAMES  = CNT_W'(MaxFramesPerCol);
    localparam logic [CNT_W-1:0] NUM_ROWS    = CNT_W'(NumRows);
    localparam logic [CNT_W-1:0] COL_ID      = CNT_W'(ColIndex);
    localparam logic [3:0]       STROBE_LAST = 4'(StrobeCycles - 1);

    logic [1:0]                 state_q;
    logic [CNT_W-1:0]           cnt_q;
    logic [CNT_W-1:0]           n_q;
    logic [CNT_W-1:0]           frame_q;
    logic [3:0]                 scnt_q;
    logic [MaxFramesPerCol-1:0] strobe_onehot;
    hdr_t                       hdr;
    logic                       accept;
    logic                       last_word;
    logic                       frame_ok;
    logic                       len_ok;

    assign hdr       = hdr_t'(cfg_data[COL_MSB:CNT_LSB]);
    assign accept    = cfg_valid && cfg_ready;
    assign last_word = (cnt_q == n_q - 1'b1);
    assign frame_ok  = (hdr.frame < MAX_FRAMES);
    assign len_ok    = (hdr.n <= NUM_ROWS);
    assign busy      = (state_q != ST_IDLE);

    frame_strobe_decode #(
        .MaxFramesPerCol(MaxFramesPerCol),
        .IdxW           (CNT_W)
    ) u_decode (
        .frame_idx(frame_q),
        .en       (state_q == ST_LOAD),
        .one_hot  (strobe_onehot)
    );

    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            n_q         <= '0;
            frame_q     <= '0;
            scnt_q      <= '0;
            cfg_ready   <= 1'b0;
            FrameData   <= '0;
            FrameStrobe <= '0;
            err         <= 1'b0;
        end else begin
            cfg_ready <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        cnt_q <= '0;
                        if (cfg_data[HDR_MARK_BIT] != HDR_MARKER) begin
                            err <= 1'b1;
                        end else if (hdr.n == '0) begin
                            err <= 1'b1;
                        end else begin
                            n_q     <= hdr.n;
                            frame_q <= hdr.frame;
                            // Malformed packets are still drained so the stream stays aligned.
                            if (!frame_ok || !len_ok) begin
                                err     <= 1'b1;
                                state_q <= ST_SKIP;
                            end else if (hdr.col == COL_ID) begin
                                state_q <= ST_LOAD;
                            end else begin
                                state_q <= ST_SKIP;
                            end
                        end
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        for (int r = 0; r < NumRows; r++) begin
                            if (cnt_q == CNT_W'(r)) begin
                                FrameData[r*FrameBitsPerRow +: FrameBitsPerRow] <= cfg_data;
                            end
                        end
                        cnt_q <= cnt_q + 1'b1;
                        if (last_word) begin
                            state_q     <= ST_STROBE;
                            cfg_ready   <= 1'b0;
                            FrameStrobe <= strobe_onehot;
                            scnt_q      <= '0;
                        end
                    end
                end
                ST_SKIP: begin
                    if (accept) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (last_word) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_STROBE: begin
                    if (scnt_q == STROBE_LAST) begin
                        state_q     <= ST_IDLE;
                        FrameStrobe <= '0;
                    end else begin
                        scnt_q    <= scnt_q + 1'b1;
                        cfg_ready <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_strobe_sequencer.sv
// Scenario-driven bench for frame_strobe_sequencer with a packet-level reference model.
module tb_frame_strobe_sequencer;

    localparam int MF = 20;
    localparam int FB = 32;
    localparam int NR = 16;
    localparam int S  = 2;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               cfg_valid = 1'b0;
    logic [FB-1:0]      cfg_data = '0;
    logic               cfg_ready;
    logic [FB*NR-1:0]   FrameData;
    logic [MF-1:0]      FrameStrobe;
    logic               busy;
    logic               err;

    int                 vectors = 0;
    int                 miscompares = 0;
    logic [FB*NR-1:0]   exp_fd = '0;
    bit                 exp_err = 1'b0;
    logic [31:0]        words[$];

    always #5 clk = ~clk;

    frame_strobe_sequencer #(
        .MaxFramesPerCol(MF),
        .FrameBitsPerRow(FB),
        .NumRows        (NR),
        .ColIndex       (0),
        .StrobeCycles   (S)
    ) dut (
        .UserCLK    (clk),
        .resetn     (rstn),
        .cfg_valid  (cfg_valid),
        .cfg_data   (cfg_data),
        .cfg_ready  (cfg_ready),
        .FrameData  (FrameData),
        .FrameStrobe(FrameStrobe),
        .busy       (busy),
        .err        (err)
    );

    function automatic logic [31:0] hdr(input int col, input int frame, input int n);
        logic [31:0] h;
        h        = 32'h8000_0000;
        h[23:16] = col[7:0];
        h[15:8]  = frame[7:0];
        h[7:0]   = n[7:0];
        return h;
    endfunction

    function automatic logic [MF-1:0] onehot(input int frame);
        logic [MF-1:0] v;
        v        = '0;
        v[frame] = 1'b1;
        return v;
    endfunction

    // Presents one word (after an optional idle gap) and returns at the edge that accepts it.
    task automatic put_word(input logic [31:0] w, input int gap);
        bit done;
        done = 1'b0;
        @(negedge clk);
        if (gap > 0) begin
            cfg_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        cfg_valid = 1'b1;
        cfg_data  = w;
        for (int i = 0; i < 64 && !done; i++) begin
            if (cfg_ready) begin
                @(posedge clk);
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL put_word_timeout: word %h not accepted, cfg_ready=%b required 1", w, cfg_ready);
        end
    endtask

    task automatic send_packet(input logic [31:0] h, input int n, input int maxgap);
        logic [31:0] w;
        words.delete();
        put_word(h, 0);
        for (int k = 0; k < n; k++) begin
            w = $urandom;
            words.push_back(w);
            put_word(w, (maxgap > 0) ? $urandom_range(0, maxgap) : 0);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        cfg_valid = 1'b0;
        rstn      = 1'b0;
        @(negedge clk);
        rstn    = 1'b1;
        exp_fd  = '0;
        exp_err = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstn      = 1'b0;
        cfg_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (cfg_ready !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || FrameStrobe !== '0 || FrameData !== '0) begin
            miscompares++;
            $display("FAIL reset_state: ready=%b busy=%b err=%b strobe=%h fd_zero=%b required 0 0 0 0 1",
                     cfg_ready, busy, err, FrameStrobe, FrameData == '0);
        end
        rstn = 1'b1;
        #1;
        vectors++;
        if (cfg_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release_ready: cfg_ready=%b required 0 before first edge", cfg_ready);
        end
        @(negedge clk);
        vectors++;
        if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_first_edge: ready=%b busy=%b required 1 0", cfg_ready, busy);
        end
    endtask

    task automatic test_load_basic();
        put_word(hdr(0, 3, 2), 0);
        put_word(32'hA5A5_A5A5, 0);
        put_word(32'h5A5A_5A5A, 0);
        exp_fd[0*FB +: FB] = 32'hA5A5_A5A5;
        exp_fd[1*FB +: FB] = 32'h5A5A_5A5A;
        @(negedge clk);
        cfg_valid = 1'b0;
        for (int c = 0; c < S; c++) begin
            vectors++;
            if (FrameStrobe !== 20'h00008 || cfg_ready !== 1'b0 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL load_basic_strobe c%0d: strobe=%h ready=%b busy=%b required 00008 0 1",
                         c, FrameStrobe, cfg_ready, busy);
            end
            vectors++;
            if (FrameData !== exp_fd) begin
                miscompares++;
                $display("FAIL load_basic_data c%0d: got %h required %h", c, FrameData[63:0], exp_fd[63:0]);
            end
            @(negedge clk);
        end
        vectors++;
        if (FrameStrobe !== '0 || cfg_ready !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL load_basic_end: strobe=%h ready=%b busy=%b err=%b required 0 1 0 0",
                     FrameStrobe, cfg_ready, busy, err);
        end
    endtask

    task automatic test_skip_other_col();
        send_packet(hdr(1, 3, 3), 3, 0);
        @(negedge clk);
        cfg_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            vectors++;
            if (FrameStrobe !== '0 || busy !== 1'b0 || err !== 1'b0 || cfg_ready !== 1'b1 || FrameData !== exp_fd) begin
                miscompares++;
                $display("FAIL skip_other_col c%0d: strobe=%h busy=%b err=%b ready=%b fd_ok=%b required 0 0 0 1 1",
                         c, FrameStrobe, busy, err, cfg_ready, FrameData === exp_fd);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_bad_frame();
        send_packet(hdr(0, 20, 1), 1, 0);
        exp_err = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        vectors++;
        if (err !== 1'b1 || busy !== 1'b0 || FrameStrobe !== '0 || FrameData !== exp_fd) begin
            miscompares++;
            $display("FAIL bad_frame: err=%b busy=%b strobe=%h fd_ok=%b required 1 0 0 1",
                     err, busy, FrameStrobe, FrameData === exp_fd);
        end
        send_packet(hdr(0, 19, 1), 1, 0);
        exp_fd[0 +: FB] = words[0];
        @(negedge clk);
        cfg_valid = 1'b0;
        for (int c = 0; c < S; c++) begin
            vectors++;
            if (FrameStrobe !== onehot(19) || FrameData !== exp_fd) begin
                miscompares++;
                $display("FAIL frame19_strobe c%0d: strobe=%h required %h fd_ok=%b",
                         c, FrameStrobe, onehot(19), FrameData === exp_fd);
            end
            @(negedge clk);
        end
        vectors++;
        if (FrameStrobe !== '0 || err !== 1'b1) begin
            miscompares++;
            $display("FAIL frame19_end: strobe=%h err=%b required 0 1", FrameStrobe, err);
        end
    endtask

    task automatic test_zero_len();
        apply_reset();
        put_word(hdr(0, 1, 0), 0);
        @(negedge clk);
        cfg_valid = 1'b0;
        vectors++;
        if (err !== 1'b1 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL zero_len: err=%b busy=%b ready=%b required 1 0 1", err, busy, cfg_ready);
        end
        put_word(32'h0000_1234, 0);
        @(negedge clk);
        cfg_valid = 1'b0;
        vectors++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL nonheader_after_err: err=%b busy=%b required 1 0", err, busy);
        end
        apply_reset();
        put_word(32'h7FFF_0001, 0);
        @(negedge clk);
        cfg_valid = 1'b0;
        vectors++;
        if (err !== 1'b1 || busy !== 1'b0 || FrameStrobe !== '0) begin
            miscompares++;
            $display("FAIL nonheader_fresh: err=%b busy=%b strobe=%h required 1 0 0", err, busy, FrameStrobe);
        end
        exp_err = 1'b1;
    endtask

    task automatic test_stall();
        put_word(hdr(0, 7, 2), 0);
        put_word(32'h1111_2222, 0);
        exp_fd[0 +: FB] = 32'h1111_2222;
        for (int g = 0; g < 2; g++) begin
            @(negedge clk);
            cfg_valid = 1'b0;
            vectors++;
            if (FrameStrobe !== '0 || busy !== 1'b1 || cfg_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL stall_gap%0d: strobe=%h busy=%b ready=%b required 0 1 1", g, FrameStrobe, busy, cfg_ready);
            end
        end
        put_word(32'h3333_4444, 0);
        exp_fd[FB +: FB] = 32'h3333_4444;
        @(negedge clk);
        cfg_valid = 1'b0;
        for (int c = 0; c < S; c++) begin
            vectors++;
            if (FrameStrobe !== onehot(7) || FrameData !== exp_fd) begin
                miscompares++;
                $display("FAIL stall_strobe c%0d: strobe=%h required %h data=%h required %h",
                         c, FrameStrobe, onehot(7), FrameData[63:0], exp_fd[63:0]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_in_strobe();
        send_packet(hdr(0, 5, 2), 2, 0);
        @(negedge clk);
        cfg_valid = 1'b0;
        vectors++;
        if (FrameStrobe !== onehot(5)) begin
            miscompares++;
            $display("FAIL rst_strobe_first: strobe=%h required %h", FrameStrobe, onehot(5));
        end
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        vectors++;
        if (FrameStrobe !== '0 || FrameData !== '0 || cfg_ready !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_in_strobe: strobe=%h fd_zero=%b ready=%b busy=%b err=%b required 0 1 0 0 0",
                     FrameStrobe, FrameData == '0, cfg_ready, busy, err);
        end
        exp_fd  = '0;
        exp_err = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        vectors++;
        if (cfg_ready !== 1'b1 || busy !== 1'b0 || FrameStrobe !== '0) begin
            miscompares++;
            $display("FAIL rst_release: ready=%b busy=%b strobe=%h required 1 0 0", cfg_ready, busy, FrameStrobe);
        end
    endtask

    task automatic test_random();
        int col, frame, n;
        bit is_load;
        for (int p = 0; p < 40; p++) begin
            col   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 255) : 0;
            frame = $urandom_range(0, MF + 3);
            n     = ($urandom_range(0, 9) == 0) ? $urandom_range(NR + 1, 40) : $urandom_range(0, NR);
            send_packet(hdr(col, frame, n), n, 2);
            is_load = (n != 0) && (col == 0) && (frame < MF) && (n <= NR);
            if (n == 0 || frame >= MF || n > NR) exp_err = 1'b1;
            if (is_load) begin
                for (int k = 0; k < n; k++) exp_fd[k*FB +: FB] = words[k];
            end
            @(negedge clk);
            cfg_valid = 1'b0;
            if (is_load) begin
                for (int c = 0; c < S; c++) begin
                    vectors++;
                    if (FrameStrobe !== onehot(frame) || cfg_ready !== 1'b0 || busy !== 1'b1) begin
                        miscompares++;
                        $display("FAIL rand_strobe p%0d c%0d: strobe=%h ready=%b busy=%b required %h 0 1",
                                 p, c, FrameStrobe, cfg_ready, busy, onehot(frame));
                    end
                    @(negedge clk);
                end
            end
            vectors++;
            if (FrameStrobe !== '0 || busy !== 1'b0 || cfg_ready !== 1'b1 || err !== exp_err) begin
                miscompares++;
                $display("FAIL rand_idle p%0d: strobe=%h busy=%b ready=%b err=%b required 0 0 1 %b",
                         p, FrameStrobe, busy, cfg_ready, err, exp_err);
            end
            vectors++;
            if (FrameData !== exp_fd) begin
                miscompares++;
                $display("FAIL rand_data p%0d: got %h required %h", p, FrameData, exp_fd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_skip_other_col();
        test_bad_frame();
        test_zero_len();
        test_stall();
        test_reset_in_strobe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
